// File: rtl/aes128_decipher_pkg.sv
// Shared KMU definitions for the AES-128 block decryptor: FSM states, Rcon and
// the GF(2^8) / FIPS byte-order helpers used by the key schedule and inverse rounds.
package aes128_decipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Entry 0 is unused; the schedule only reads rounds 1..10.
    localparam logic [10:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    // Byte k of a block sits at [127-8k -: 8]; bytes are column-major (k = 4c + r).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes128_invround.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes128_invround
    import aes128_decipher_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         lastround_i,
    output logic [127:0] st_o
);

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mix;

    assign sr = inv_shift_rows(st_i);

    for (genvar k = 0; k < 16; k++) begin : g_isbox
        assign sb[127-8*k -: 8] = inv_sbox(sr[127-8*k -: 8]);
    end

    assign ark = sb ^ rk_i;

    for (genvar c = 0; c < 4; c++) begin : g_imix
        assign mix[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end

    assign st_o = lastround_i ? ark : mix;

endmodule

// File: rtl/aes128_decipher.sv
// Iterative AES-128 block decryptor: forward key expansion into an 11-entry
// round-key buffer, then inverse rounds 10..0, with optional round-key reuse.
module aes128_decipher
    import aes128_decipher_pkg::*;
#(
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         Flush,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] Key,
    input  logic [127:0] CipherText,
    input  logic         KeyReuse,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] PlainText,
    output logic         Busy
);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;
    logic         kcv_q, kcv_d;

    logic [127:0] rk_q [0:10];
    logic         rk_we;
    logic [3:0]   rk_wa;
    logic [127:0] rk_wd;

    logic         reuse;
    logic [3:0]   ks_idx;
    logic [127:0] ks_in, ks_out;
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [127:0] rk_rd, round_out;

    assign reuse = KEY_CACHE_EN && KeyReuse && kcv_q;

    // KeyStep: rk[cnt] from rk[cnt-1]; index clamped so idle cycles stay in range.
    assign ks_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign ks_in  = rk_q[ks_idx];
    assign {w0, w1, w2, w3} = ks_in;
    assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {RCON[cnt_q], 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign ks_out = {n0, n1, n2, n3};

    assign rk_rd = rk_q[rnd_q];

    aes128_invround u_invround (
        .st_i        (st_q),
        .rk_i        (rk_rd),
        .lastround_i (rnd_q == 4'd0),
        .st_o        (round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        pt_d    = pt_q;
        kcv_d   = kcv_q;
        rk_we   = 1'b0;
        rk_wa   = cnt_q;
        rk_wd   = ks_out;
        if (Flush) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            kcv_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (InValid) begin
                        if (reuse) begin
                            st_d    = CipherText ^ rk_q[10];
                            rnd_d   = 4'd9;
                            state_d = ST_ROUND;
                        end else begin
                            // Cache is invalid until this expansion completes.
                            rk_we   = 1'b1;
                            rk_wa   = 4'd0;
                            rk_wd   = Key;
                            st_d    = CipherText;
                            cnt_d   = 4'd1;
                            kcv_d   = 1'b0;
                            state_d = ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    rk_we = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd10) begin
                        st_d    = st_q ^ ks_out;
                        cnt_d   = 4'd0;
                        kcv_d   = 1'b1;
                        rnd_d   = 4'd9;
                        state_d = ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (rnd_q == 4'd0) begin
                        pt_d    = round_out;
                        state_d = ST_DONE;
                    end else begin
                        st_d  = round_out;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (OutReady) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rnd_q   <= 4'd0;
            st_q    <= '0;
            pt_q    <= '0;
            kcv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            kcv_q   <= kcv_d;
        end
    end

    // Round-key buffer carries no reset; validity lives in kcv_q.
    always_ff @(posedge clk) begin
        if (rk_we) rk_q[rk_wa] <= rk_wd;
    end

    assign InReady   = (state_q == ST_IDLE);
    assign OutValid  = (state_q == ST_DONE);
    assign Busy      = (state_q == ST_EXPAND) || (state_q == ST_ROUND);
    assign PlainText = pt_q;

endmodule

// File: tb/tb_aes128_decipher.sv
// Directed FIPS-197 vectors for aes128_decipher: latency, key reuse, backpressure,
// flush, async reset and back-to-back streaming.
module tb_aes128_decipher;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         Flush = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [127:0] Key = '0;
    logic [127:0] CipherText = '0;
    logic         KeyReuse = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [127:0] PlainText;
    logic         Busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_decipher #(.KEY_CACHE_EN(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .Key        (Key),
        .CipherText (CipherText),
        .KeyReuse   (KeyReuse),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .PlainText  (PlainText),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one request while IDLE; returns in cycle 1 after the acceptance edge.
    task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic reuse);
        for (int i = 0; i < 50 && !InReady; i++) begin
            @(posedge clk); #1;
        end
        Key = k; CipherText = c; KeyReuse = reuse; InValid = 1'b1;
        @(posedge clk); #1;
        InValid    = 1'b0;
        KeyReuse   = 1'($urandom_range(0, 1));
        Key        = {$urandom, $urandom, $urandom, $urandom};
        CipherText = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int cyc, output int busy);
        cyc = 1; busy = 0;
        while (!OutValid && cyc < 100) begin
            if (Busy) busy++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL reset_inready: got %b want 1", InReady); end
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (PlainText !== 128'h0) begin n_bad++; $display("FAIL reset_pt: got %h want 0", PlainText); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_c1();
        int cyc, busy;
        OutReady = 1'b1;
        issue(K1, C1, 1'b0);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL c1_latency: got %0d want 21", cyc); end
        n_cmp++; if (busy !== 20) begin n_bad++; $display("FAIL c1_busy_cycles: got %0d want 20", busy); end
        n_cmp++; if (PlainText !== P1) begin n_bad++; $display("FAIL c1_pt: got %h want %h", PlainText, P1); end
        @(posedge clk); #1;
        n_cmp++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            n_bad++; $display("FAIL c1_return_idle: got rdy=%b vld=%b want rdy=1 vld=0", InReady, OutValid); end
    endtask

    task automatic test_appb_reuse();
        int cyc, busy;
        issue(K2, C2, 1'b0);
        wait_out(cyc, busy);
        n_cmp++; if (PlainText !== P2) begin n_bad++; $display("FAIL appb_pt: got %h want %h", PlainText, P2); end
        n_cmp++; if (dut.rk_q[10] !== RK10) begin n_bad++; $display("FAIL appb_rk10: got %h want %h", dut.rk_q[10], RK10); end
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL appb_latency: got %0d want 21", cyc); end
        @(posedge clk); #1;
        // Key port carries an unrelated key: the cached schedule must be used.
        issue(K1, C2, 1'b1);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL reuse_latency: got %0d want 11", cyc); end
        n_cmp++; if (PlainText !== P2) begin n_bad++; $display("FAIL reuse_pt: got %h want %h", PlainText, P2); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc, busy;
        OutReady = 1'b0;
        issue(K1, C2, 1'b1);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL bp_latency: got %0d want 11", cyc); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (OutValid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, OutValid); end
            n_cmp++; if (PlainText !== P2) begin n_bad++; $display("FAIL bp_hold_pt[%0d]: got %h want %h", i, PlainText, P2); end
            n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL bp_inready[%0d]: got %b want 0", i, InReady); end
            @(posedge clk); #1;
        end
        OutReady = 1'b1;
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL bp_release_cycle: got %b want 0", InReady); end
        @(posedge clk); #1;
        n_cmp++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            n_bad++; $display("FAIL bp_after_release: got rdy=%b vld=%b want rdy=1 vld=0", InReady, OutValid); end
    endtask

    task automatic test_flush();
        int cyc, busy;
        // Flush together with a reuse request: nothing accepted, cache dropped.
        Flush = 1'b1; InValid = 1'b1; Key = K1; CipherText = C1; KeyReuse = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0; InValid = 1'b0;
        n_cmp++; if (InReady !== 1'b1 || Busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_with_valid: got rdy=%b busy=%b want rdy=1 busy=0", InReady, Busy); end
        issue(K1, C1, 1'b1);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL flush_idle_latency: got %0d want 21", cyc); end
        n_cmp++; if (PlainText !== P1) begin n_bad++; $display("FAIL flush_idle_pt: got %h want %h", PlainText, P1); end
        @(posedge clk); #1;
        // Abort an expansion of K2 at cnt = 4.
        issue(K2, C2, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (dut.cnt_q !== 4'd4) begin n_bad++; $display("FAIL flush_cnt: got %0d want 4", dut.cnt_q); end
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        n_cmp++; if (InReady !== 1'b1 || Busy !== 1'b0 || OutValid !== 1'b0) begin
            n_bad++; $display("FAIL flush_expand_idle: got rdy=%b busy=%b vld=%b want 1 0 0", InReady, Busy, OutValid); end
        issue(K1, C1, 1'b1);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL flush_expand_latency: got %0d want 21", cyc); end
        n_cmp++; if (PlainText !== P1) begin n_bad++; $display("FAIL flush_expand_pt: got %h want %h", PlainText, P1); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int cyc, busy;
        issue(K1, C1, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++; if (dut.rnd_q !== 4'd5) begin n_bad++; $display("FAIL arst_rnd: got %0d want 5", dut.rnd_q); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (OutValid !== 1'b0 || Busy !== 1'b0 || InReady !== 1'b1) begin
            n_bad++; $display("FAIL arst_outputs: got vld=%b busy=%b rdy=%b want 0 0 1", OutValid, Busy, InReady); end
        n_cmp++; if (PlainText !== 128'h0) begin n_bad++; $display("FAIL arst_pt: got %h want 0", PlainText); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(K1, C1, 1'b1);
        wait_out(cyc, busy);
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL arst_latency: got %0d want 21", cyc); end
        n_cmp++; if (PlainText !== P1) begin n_bad++; $display("FAIL arst_pt_after: got %h want %h", PlainText, P1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int acc, outs, cyc, acc_cyc, want;
        acc = 0; outs = 0; cyc = 0; acc_cyc = 0;
        OutReady = 1'b1;
        InValid = 1'b1; Key = K1; CipherText = C1; KeyReuse = 1'b0;
        while (outs < 3 && cyc < 300) begin
            if (InReady) begin
                KeyReuse = (acc != 0);
                acc++;
                acc_cyc = cyc;
            end
            if (OutValid) begin
                want = (outs == 0) ? 21 : 11;
                n_cmp++; if (PlainText !== P1) begin n_bad++; $display("FAIL b2b_pt[%0d]: got %h want %h", outs, PlainText, P1); end
                n_cmp++; if (cyc - acc_cyc !== want) begin
                    n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", outs, cyc - acc_cyc, want); end
                outs++;
                if (outs == 3) InValid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        InValid = 1'b0;
        n_cmp++; if (outs !== 3) begin n_bad++; $display("FAIL b2b_outputs: got %0d want 3", outs); end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (acc !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_cmp++; if (Busy !== 1'b0 || InReady !== 1'b1) begin
            n_bad++; $display("FAIL b2b_final_idle: got busy=%b rdy=%b want 0 1", Busy, InReady); end
    endtask

    initial begin
        test_reset();
        test_c1();
        test_appb_reuse();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
